// File: rtl/muldiv_scheduler_if.sv
// Connection between muldiv_scheduler (master) and the external multi-cycle mult/div unit (slave).
// The scheduler drives start, operation and operands; the unit returns the HI/LO result words.
interface muldiv_scheduler_if;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (output md_start, md_op, md_a, md_b, input md_hi, md_lo);
  modport slave  (input md_start, md_op, md_a, md_b, output md_hi, md_lo);
endinterface

// File: rtl/muldiv_scheduler.sv
// Schedules MULT/MULTU/DIV/DIVU on the shared mult/div unit and owns HI/LO.
// Define MULDIV_FWD_EN to serve MFHI/MFLO straight from the unit during write-back.
module muldiv_scheduler #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                valid_in,
  input  logic [5:0]          opcode_in,
  input  logic [5:0]          func_in,
  input  logic [31:0]         rs_val,
  input  logic [31:0]         rt_val,
  output logic                stall_out,
  muldiv_scheduler_if.master  md,
  output logic                mf_valid_out,
  output logic [31:0]         mf_data_out,
  output logic                busy_out,
  output logic                div_zero_out
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_md_a;
  logic [31:0]   r_md_b;
  logic [1:0]    r_md_op;
  logic          r_md_start;
  logic          r_div_zero;

  logic w_is_r, w_is_md, w_is_mfhi, w_is_mflo, w_is_mf;
  logic w_idle, w_mf_ok, w_md_acc, w_div_zero, w_md_go;

  assign w_is_r    = valid_in && (opcode_in == 6'b000000);
  assign w_is_md   = w_is_r && (func_in[5:2] == 4'b0110);
  assign w_is_mfhi = w_is_r && (func_in == 6'b010000);
  assign w_is_mflo = w_is_r && (func_in == 6'b010010);
  assign w_is_mf   = w_is_mfhi || w_is_mflo;
  assign w_idle    = (r_state == S_IDLE);

`ifdef MULDIV_FWD_EN
  assign w_mf_ok = w_idle || (r_state == S_WB);
`else
  assign w_mf_ok = w_idle;
`endif

  assign stall_out  = (w_is_md && !w_idle) || (w_is_mf && !w_mf_ok);
  assign w_md_acc   = w_is_md && w_idle;
  // A divide by zero never reaches the unit; HI/LO keep their old contents.
  assign w_div_zero = w_md_acc && func_in[1] && (rt_val == 32'd0);
  assign w_md_go    = w_md_acc && !w_div_zero;

  assign mf_valid_out = w_is_mf && w_mf_ok;
  assign busy_out     = !w_idle;
  assign div_zero_out = r_div_zero;

  assign md.md_start = r_md_start;
  assign md.md_op    = r_md_op;
  assign md.md_a     = r_md_a;
  assign md.md_b     = r_md_b;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mf_data_out = 32'd0;
    if (mf_valid_out) begin
`ifdef MULDIV_FWD_EN
      if (r_state == S_WB) mf_data_out = w_is_mfhi ? md.md_hi : md.md_lo;
      else                 mf_data_out = w_is_mfhi ? r_hi : r_lo;
`else
      mf_data_out = w_is_mfhi ? r_hi : r_lo;
`endif
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_md_a     <= 32'd0;
      r_md_b     <= 32'd0;
      r_md_op    <= 2'b00;
      r_md_start <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_md_start <= w_md_go;
      r_div_zero <= w_div_zero;
      case (r_state)
        S_IDLE: begin
          if (w_md_go) begin
            r_md_a  <= rs_val;
            r_md_b  <= rt_val;
            r_md_op <= func_in[1:0];
            r_cnt   <= func_in[1] ? DIV_LOAD : MULT_LOAD;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) r_state <= S_WB;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_WB: begin
          r_hi    <= md.md_hi;
          r_lo    <= md.md_lo;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed self-checking bench for muldiv_scheduler with a latency-accurate mult/div unit model.
// Expected results are hand-computed constants; build with MULDIV_FWD_EN to cover forwarding.
module tb_muldiv_scheduler;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

`ifdef MULDIV_FWD_EN
  localparam int EXP_MF_STALL = MULT_LAT;
`else
  localparam int EXP_MF_STALL = MULT_LAT + 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [5:0]  opcode_in;
  logic [5:0]  func_in;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall_out;
  logic        mf_valid_out;
  logic [31:0] mf_data_out;
  logic        busy_out;
  logic        div_zero_out;

  int n_err = 0;
  int n_chk = 0;

  muldiv_scheduler_if md_if ();

  muldiv_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .opcode_in    (opcode_in),
    .func_in      (func_in),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .stall_out    (stall_out),
    .md           (md_if.master),
    .mf_valid_out (mf_valid_out),
    .mf_data_out  (mf_data_out),
    .busy_out     (busy_out),
    .div_zero_out (div_zero_out)
  );

  always #5 clock = ~clock;

  // Unit model: result becomes valid LAT cycles after the start cycle, garbage before that.
  int          cyc = 0;
  int          st_c;
  int          lat;
  logic        pend;
  logic [63:0] res;
  int          n_start;

  function automatic logic [63:0] unit_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'd0;
    case (op)
      2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: if (b != 0) p = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      default: if (b != 0) p = {a % b, a / b};
    endcase
    return p;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= 1'b0;
      n_start <= 0;
      st_c    <= 0;
      lat     <= 0;
      res     <= 64'd0;
    end else begin
      cyc <= cyc + 1;
      if (md_if.md_start) begin
        pend    <= 1'b1;
        st_c    <= cyc;
        lat     <= md_if.md_op[1] ? DIV_LAT : MULT_LAT;
        res     <= unit_fn(md_if.md_op, md_if.md_a, md_if.md_b);
        n_start <= n_start + 1;
      end
    end
  end

  assign md_if.md_hi = (pend && (cyc - st_c >= lat)) ? res[63:32] : 32'hDEADBEEF;
  assign md_if.md_lo = (pend && (cyc - st_c >= lat)) ? res[31:0]  : 32'hBADC0DE5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    valid_in  = 1'b1;
    opcode_in = 6'b000000;
    func_in   = fn;
    rs_val    = rs;
    rt_val    = rt;
  endtask

  task automatic nop();
    valid_in  = 1'b0;
    opcode_in = 6'b000000;
    func_in   = 6'b000000;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
  endtask

  // Issue an md op in IDLE and wait for it to complete (bounded).
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    drive(fn, rs, rt);
    next();
    nop();
    n = 0;
    while (busy_out && n < 100) begin
      next();
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'(busy_out), 32'd0);
  endtask

  task automatic read_mf(input string tag, input logic [5:0] fn, input logic [31:0] exp);
    drive(fn, 32'd0, 32'd0);
    @(negedge clock);
    check({tag, "_valid"}, 32'(mf_valid_out), 32'd1);
    check(tag, mf_data_out, exp);
    next();
    nop();
  endtask

  initial begin
    int stalls;
    int bc;
    int n0;
    logic a_bad;

    reset_n = 1'b0;
    nop();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_start", 32'(md_if.md_start), 32'd0);
    check("rst_md_a", md_if.md_a, 32'd0);
    check("rst_md_op", 32'(md_if.md_op), 32'd0);
    check("rst_div_zero", 32'(div_zero_out), 32'd0);
    next();
    reset_n = 1'b1;
    next();

    // Unrelated R-type instruction is ignored.
    drive(6'b100000, 32'd1, 32'd2);
    @(negedge clock);
    check("add_stall", 32'(stall_out), 32'd0);
    check("add_mf_valid", 32'(mf_valid_out), 32'd0);
    next();
    nop();
    @(negedge clock);
    check("add_no_start", 32'(md_if.md_start), 32'd0);
    next();

    // MULT 0x10000 * 0x10000 -> HI=1, LO=0; MFHI held behind it.
    drive(F_MULT, 32'h0001_0000, 32'h0001_0000);
    @(negedge clock);
    check("mult_accept", 32'(stall_out), 32'd0);
    next();
    drive(F_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    check("mult_start", 32'(md_if.md_start), 32'd1);
    check("mult_md_a", md_if.md_a, 32'h0001_0000);
    check("mult_md_op", 32'(md_if.md_op), 32'd0);
    stalls = 0;
    a_bad  = 1'b0;
    while (stall_out && stalls < 50) begin
      if (md_if.md_a !== 32'h0001_0000 || md_if.md_b !== 32'h0001_0000) a_bad = 1'b1;
      stalls++;
      next();
      @(negedge clock);
    end
    check("mult_mfhi_stall_cycles", 32'(stalls), 32'(EXP_MF_STALL));
    check("mult_operands_stable", 32'(a_bad), 32'd0);
    check("mult_mfhi_valid", 32'(mf_valid_out), 32'd1);
    check("mult_mfhi", mf_data_out, 32'h0000_0001);
    next();
    nop();
    check("mult_start_count", 32'(n_start), 32'd1);
    read_mf("mult_mflo", F_MFLO, 32'h0000_0000);

    // DIVU 100 / 7 -> LO=14, HI=2; busy for DIV_LAT+1 cycles; other opcodes never stalled.
    drive(F_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    check("divu_accept", 32'(stall_out), 32'd0);
    next();
    valid_in  = 1'b1;
    opcode_in = 6'b100011;
    @(negedge clock);
    check("lw_not_stalled", 32'(stall_out), 32'd0);
    bc = 0;
    while (busy_out && bc < 100) begin
      bc++;
      next();
      nop();
      @(negedge clock);
    end
    check("divu_busy_cycles", 32'(bc), 32'(DIV_LAT + 1));
    next();
    read_mf("divu_mflo", F_MFLO, 32'd14);
    read_mf("divu_mfhi", F_MFHI, 32'd2);

    // Signed variants: DIV -7/2 -> q=-3 r=-1; MULT -2*3 -> -6.
    run_md("div_signed", F_DIV, 32'hFFFF_FFF9, 32'd2);
    read_mf("div_signed_lo", F_MFLO, 32'hFFFF_FFFD);
    read_mf("div_signed_hi", F_MFHI, 32'hFFFF_FFFF);
    run_md("mult_signed", F_MULT, 32'hFFFF_FFFE, 32'd3);
    read_mf("mult_signed_lo", F_MFLO, 32'hFFFF_FFFA);
    read_mf("mult_signed_hi", F_MFHI, 32'hFFFF_FFFF);

    // Preload HI=5/LO=6 via DIVU 47/7, then DIV by zero leaves them intact.
    run_md("preload", F_DIVU, 32'd47, 32'd7);
    n0 = n_start;
    drive(F_DIV, 32'd123, 32'd0);
    @(negedge clock);
    check("dz_accept", 32'(stall_out), 32'd0);
    next();
    nop();
    @(negedge clock);
    check("dz_pulse", 32'(div_zero_out), 32'd1);
    check("dz_no_start", 32'(md_if.md_start), 32'd0);
    check("dz_busy", 32'(busy_out), 32'd0);
    next();
    @(negedge clock);
    check("dz_pulse_end", 32'(div_zero_out), 32'd0);
    check("dz_start_count", 32'(n_start - n0), 32'd0);
    next();
    read_mf("dz_mfhi", F_MFHI, 32'd5);
    read_mf("dz_mflo", F_MFLO, 32'd6);

    // Back-to-back MULT 3*5 then DIVU 50/6 held continuously.
    drive(F_MULT, 32'd3, 32'd5);
    next();
    drive(F_DIVU, 32'd50, 32'd6);
    @(negedge clock);
    stalls = 0;
    a_bad  = 1'b0;
    while (stall_out && stalls < 50) begin
      if (md_if.md_a !== 32'd3 || md_if.md_b !== 32'd5 || md_if.md_op !== 2'b00) a_bad = 1'b1;
      stalls++;
      next();
      @(negedge clock);
    end
    check("b2b_divu_stall_cycles", 32'(stalls), 32'(MULT_LAT + 1));
    check("b2b_mult_operands_stable", 32'(a_bad), 32'd0);
    next();
    nop();
    @(negedge clock);
    check("b2b_divu_start", 32'(md_if.md_start), 32'd1);
    check("b2b_divu_md_a", md_if.md_a, 32'd50);
    check("b2b_divu_md_op", 32'(md_if.md_op), 32'd3);
    bc = 0;
    a_bad = 1'b0;
    while (busy_out && bc < 100) begin
      if (md_if.md_a !== 32'd50 || md_if.md_b !== 32'd6) a_bad = 1'b1;
      bc++;
      next();
      @(negedge clock);
    end
    check("b2b_divu_operands_stable", 32'(a_bad), 32'd0);
    next();
    read_mf("b2b_mflo", F_MFLO, 32'd8);
    read_mf("b2b_mfhi", F_MFHI, 32'd2);

    // MFLO presented in the WB cycle of MULTU 0xFFFFFFFF*2 -> LO=0xFFFFFFFE.
    drive(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    next();
    nop();
    repeat (MULT_LAT) next();
    drive(F_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    check("wb_busy", 32'(busy_out), 32'd1);
`ifdef MULDIV_FWD_EN
    check("wb_fwd_stall", 32'(stall_out), 32'd0);
    check("wb_fwd_valid", 32'(mf_valid_out), 32'd1);
    check("wb_fwd_data", mf_data_out, 32'hFFFF_FFFE);
    next();
    nop();
`else
    check("wb_stall", 32'(stall_out), 32'd1);
    check("wb_valid", 32'(mf_valid_out), 32'd0);
    next();
    @(negedge clock);
    check("wb_after_stall", 32'(stall_out), 32'd0);
    check("wb_after_valid", 32'(mf_valid_out), 32'd1);
    check("wb_after_data", mf_data_out, 32'hFFFF_FFFE);
    next();
    nop();
`endif
    read_mf("wb_mfhi", F_MFHI, 32'd1);

    // Reset asserted mid-RUN discards the in-flight MULT 7*9.
    drive(F_MULT, 32'd7, 32'd9);
    next();
    nop();
    next();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_start", 32'(md_if.md_start), 32'd0);
    next();
    reset_n = 1'b1;
    read_mf("midrst_mfhi", F_MFHI, 32'd0);
    repeat (10) next();
    check("midrst_still_idle", 32'(busy_out), 32'd0);
    read_mf("midrst_mflo", F_MFLO, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_scheduler.md
Name: muldiv_scheduler

Overview:
- Sequences the shared multi-cycle multiply/divide datapath for R-type MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- Sits beside decode and consumes its opcode/func outputs plus register-file operand values.
- Drives start and operation select to the external mult/div unit, counts its fixed latency and captures the result into HI/LO.
- Stalls decode when a new mult/div op or an MFHI/MFLO arrives while HI/LO is pending.

Parameters:
MULT_LAT, 4, cycles from md_start to valid md_hi/md_lo for MULT/MULTU (>=1)
DIV_LAT, 32, cycles from md_start to valid md_hi/md_lo for DIV/DIVU (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  decode presents a valid instruction this cycle
opcode_in  in  6  instruction opcode from decode
func_in  in  6  R-type function field from decode
rs_val  in  32  rs operand value (multiplicand/dividend)
rt_val  in  32  rt operand value (multiplier/divisor)
stall_out  out  1  hold decode; current instruction not accepted
md_start  out  1  one-cycle start pulse to mult/div unit
md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held from start through capture
md_a  out  32  latched rs operand; held stable while busy
md_b  out  32  latched rt operand; held stable while busy
md_hi  in  32  unit result, high word / remainder
md_lo  in  32  unit result, low word / quotient
mf_valid_out  out  1  MFHI/MFLO accepted this cycle
mf_data_out  out  32  HI or LO value for accepted MFHI/MFLO, else 0
busy_out  out  1  state != IDLE
div_zero_out  out  1  one-cycle pulse: DIV/DIVU with rt_val == 0 accepted

Behaviour:
- Classification applies only when valid_in=1 and opcode_in=000000. func 011000/011001/011010/011011 = md op; 010000 = MFHI; 010010 = MFLO. All other instructions are ignored and never stalled.
- Acceptance: an instruction is accepted when valid_in=1 and stall_out=0.
- States:
  - IDLE: accepted md op latches rs_val/rt_val into md_a/md_b and func[1:0] into md_op, pulses md_start next cycle, loads counter with LAT-1 (MULT_LAT or DIV_LAT by op), goes to RUN.
  - Exception: accepted DIV/DIVU with rt_val==0 does not start the unit, pulses div_zero_out the next cycle, leaves HI/LO unchanged and stays in IDLE.
  - RUN: counter decrements each cycle; on counter==0, goes to WB.
  - WB: hi_reg<=md_hi, lo_reg<=md_lo at the end of the cycle, then goes to IDLE.
  - Total: md op accepted at cycle T -> md_start at T+1 -> HI/LO updated at edge ending T+1+LAT -> back-to-back md op accepted at T+2+LAT.
- stall_out (combinational): valid_in and (md op or MFHI/MFLO) and state != IDLE.
- MFHI/MFLO in IDLE: mf_valid_out=1 and mf_data_out=hi_reg/lo_reg, combinational in the same cycle.
- Counter width is clog2(max(MULT_LAT,DIV_LAT)+1). No wrap: counter reloads only in IDLE.
- md_start never asserts outside the cycle after acceptance. md_a/md_b/md_op do not change in RUN/WB.
- Reset (asserted at any time, including mid-RUN): state=IDLE, counter=0, hi_reg=lo_reg=0, md_a=md_b=0, md_op=00, md_start=0, div_zero_out=0. The in-flight result is discarded and the unit output is ignored after reset.

Optional Feature:
MULDIV_FWD_EN
- Defined: in WB, MFHI/MFLO is not stalled; mf_valid_out=1 and mf_data_out=md_hi/md_lo taken directly from the unit. New md ops are still stalled in WB.
- Undefined: MFHI/MFLO stalls in WB and is served from hi_reg/lo_reg in the following IDLE cycle.

Test Plan:
- Reset: reset_n=0 mid-RUN for 1 cycle -> busy_out=0, md_start=0, MFHI immediately after returns 0.
- MULT rs=0x00010000, rt=0x00010000, unit model returns hi=1 lo=0 after MULT_LAT=4 -> md_start at T+1; MFHI stalls 5 cycles and then returns 0x00000001; MFLO returns 0.
- DIVU rs=100, rt=7, DIV_LAT=32 -> busy_out high 33 cycles; MFLO=14, MFHI=2.
- DIV rt=0 with HI/LO preloaded 5/6 -> no md_start, div_zero_out pulses once, busy_out stays 0, MFHI=5, MFLO=6.
- Back-to-back MULT then DIVU presented continuously -> DIVU stalled until MULT WB completes, then accepted at T+2+MULT_LAT; md_a/md_b stable throughout each op.
- MFLO presented in WB cycle -> with MULDIV_FWD_EN: no stall, data = md_lo; without: 1-cycle stall, data = lo_reg equal to md_lo.
